// File: rtl/div_iter_impl_if.sv
// div_iter_impl_if: operand/result handshake bundle between execute control and the iterative divider
interface div_iter_impl_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             busy;
  modport master (
    output flush, in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, busy
  );
  modport slave (
    input  flush, in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/div_iter_impl.sv
// div_iter_impl: restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU; define DIV_SPECIAL_FAST_EN to short-cut divide-by-zero and signed overflow
module div_iter_impl #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  div_iter_impl_if.slave d
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             is_rem, neg_q, neg_r, div0;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, rem_sh, res_q, res_r;
  logic [WIDTH:0]   diff;
  assign sa     = ~d.in_op[0] & d.in_a[WIDTH-1];
  assign sb     = ~d.in_op[0] & d.in_b[WIDTH-1];
  assign mag_a  = sa ? -d.in_a : d.in_a;
  assign mag_b  = sb ? -d.in_b : d.in_b;
  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dvs};
  // Divide-by-zero quotient is forced; its remainder and the overflow case fall out of the sign fix-up naturally.
  assign res_q  = div0 ? '1 : (neg_q ? -quo : quo);
  assign res_r  = neg_r ? -rem : rem;
  assign d.in_ready  = state == IDLE;
  assign d.out_valid = state == DONE;
  assign d.busy      = state != IDLE;
`ifdef DIV_SPECIAL_FAST_EN
  logic             fast;
  logic [WIDTH-1:0] fast_res;
  assign fast     = (d.in_b == '0) | (~d.in_op[0] & (d.in_a == {1'b1, {(WIDTH-1){1'b0}}}) & (d.in_b == '1));
  assign fast_res = d.in_b == '0 ? (d.in_op[1] ? d.in_a : '1) : (d.in_op[1] ? '0 : d.in_a);
`endif
  // Control FSM and datapath: accept, one quotient bit per CALC cycle, sign fix-up, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      is_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div0         <= 1'b0;
      d.out_result <= '0;
    end else if (d.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (d.in_valid) begin
          is_rem <= d.in_op[1];
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          div0   <= d.in_b == '0;
          quo    <= mag_a;
          dvs    <= mag_b;
          rem    <= '0;
          cnt    <= CW'(WIDTH - 1);
`ifdef DIV_SPECIAL_FAST_EN
          state        <= fast ? DONE : CALC;
          d.out_result <= fast ? fast_res : d.out_result;
`else
          state  <= CALC;
`endif
        end
        CALC: begin
          rem   <= diff[WIDTH] ? rem_sh : diff[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : CALC;
        end
        FIX: begin
          d.out_result <= is_rem ? res_r : res_q;
          state        <= DONE;
        end
        DONE: if (d.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
